// File: rtl/axil_fifo_master.sv
// AXI4-Lite master bridging a push stream to FIFO writes
// and on-demand FIFO reads to a pop stream.
module axil_fifo_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             ACLK,
  input  logic             ARESET_N,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  input  logic             rd_en,
  output logic             wr_err,
  output logic             rd_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [31:0]      AWADDR,
  output logic [2:0]       AWPROT,
  output logic             WVALID,
  input  logic             WREADY,
  output logic [31:0]      WDATA,
  output logic [3:0]       WSTRB,
  input  logic             BVALID,
  output logic             BREADY,
  input  logic [1:0]       BRESP,
  output logic             ARVALID,
  input  logic             ARREADY,
  output logic [31:0]      ARADDR,
  output logic [2:0]       ARPROT,
  input  logic             RVALID,
  output logic             RREADY,
  input  logic [31:0]      RDATA,
  input  logic [1:0]       RRESP
);

  typedef enum logic [1:0] {
    W_IDLE, W_REQ, W_RESP
  } wst_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA, R_HOLD
  } rst_t;

  localparam logic [ERR_W:0] CNT_MAX =
    {1'b0, {ERR_W{1'b1}}};

  wst_t        w_q, w_d;
  logic        aw_q, aw_d;
  logic        wv_q, wv_d;
  logic        b_q, b_d;
  logic        werr_q, werr_d;
  logic [31:0] wdat_q, wdat_d;

  rst_t        r_q, r_d;
  logic        ar_q, ar_d;
  logic        rr_q, rr_d;
  logic        mv_q, mv_d;
  logic        rerr_q, rerr_d;
  logic [31:0] mdat_q, mdat_d;

  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [ERR_W:0]   cnt_sum;

  assign AWADDR  = BASE_ADDR;
  assign ARADDR  = BASE_ADDR;
  assign AWPROT  = 3'b000;
  assign ARPROT  = 3'b000;
  assign WSTRB   = 4'hF;

  assign s_ready = (w_q == W_IDLE);
  assign AWVALID = aw_q;
  assign WVALID  = wv_q;
  assign WDATA   = wdat_q;
  assign BREADY  = b_q;
  assign wr_err  = werr_q;

  assign ARVALID = ar_q;
  assign RREADY  = rr_q;
  assign m_valid = mv_q;
  assign m_data  = mdat_q;
  assign rd_err  = rerr_q;

  assign err_cnt = cnt_q;

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      w_q    <= W_IDLE;
      aw_q   <= 1'b0;
      wv_q   <= 1'b0;
      b_q    <= 1'b0;
      werr_q <= 1'b0;
      wdat_q <= '0;
      r_q    <= R_IDLE;
      ar_q   <= 1'b0;
      rr_q   <= 1'b0;
      mv_q   <= 1'b0;
      rerr_q <= 1'b0;
      mdat_q <= '0;
      cnt_q  <= '0;
    end else begin
      w_q    <= w_d;
      aw_q   <= aw_d;
      wv_q   <= wv_d;
      b_q    <= b_d;
      werr_q <= werr_d;
      wdat_q <= wdat_d;
      r_q    <= r_d;
      ar_q   <= ar_d;
      rr_q   <= rr_d;
      mv_q   <= mv_d;
      rerr_q <= rerr_d;
      mdat_q <= mdat_d;
      cnt_q  <= cnt_d;
    end
  end

  // AW and W retire independently; B opens once both are gone
  always_comb begin
    w_d    = w_q;
    aw_d   = aw_q;
    wv_d   = wv_q;
    b_d    = b_q;
    wdat_d = wdat_q;
    werr_d = 1'b0;
    unique case (w_q)
      W_IDLE: begin
        if (s_valid) begin
          wdat_d = s_data;
          aw_d   = 1'b1;
          wv_d   = 1'b1;
          w_d    = W_REQ;
        end
      end
      W_REQ: begin
        aw_d = aw_q & ~AWREADY;
        wv_d = wv_q & ~WREADY;
        if (!aw_d && !wv_d) begin
          b_d = 1'b1;
          w_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BVALID) begin
          b_d    = 1'b0;
          werr_d = |BRESP;
          w_d    = W_IDLE;
        end
      end
      default: begin
        w_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_d    = r_q;
    ar_d   = ar_q;
    rr_d   = rr_q;
    mv_d   = mv_q;
    mdat_d = mdat_q;
    rerr_d = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        if (rd_en) begin
          ar_d = 1'b1;
          r_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ARREADY) begin
          ar_d = 1'b0;
          rr_d = 1'b1;
          r_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (RVALID) begin
          rr_d = 1'b0;
          if (RRESP == 2'b00) begin
            mdat_d = RDATA;
            mv_d   = 1'b1;
            r_d    = R_HOLD;
          end else begin
            rerr_d = 1'b1;
            r_d    = R_IDLE;
          end
        end
      end
      R_HOLD: begin
        if (m_ready) begin
          mv_d = 1'b0;
          r_d  = R_IDLE;
        end
      end
      default: begin
        r_d = R_IDLE;
      end
    endcase
  end

  // one extra bit catches the overflow before clamping
  assign cnt_sum = {1'b0, cnt_q}
                 + {{ERR_W{1'b0}}, werr_q}
                 + {{ERR_W{1'b0}}, rerr_q};

  always_comb begin
    cnt_d = cnt_sum[ERR_W-1:0];
    if (cnt_sum > CNT_MAX) begin
      cnt_d = CNT_MAX[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_axil_fifo_master.sv
// Bench for axil_fifo_master: FIFO slave model plus
// queued scoreboard for writes, pops and the error counter.
module tb_axil_fifo_master;

  localparam logic [31:0] BASE = 32'h4000_0010;

  logic        ACLK = 1'b0;
  logic        ARESET_N;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        rd_en, wr_err, rd_err;
  logic [7:0]  err_cnt;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  axil_fifo_master #(
    .BASE_ADDR(BASE),
    .ERR_W    (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESET_N(ARESET_N),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .rd_en   (rd_en),
    .wr_err  (wr_err),
    .rd_err  (rd_err),
    .err_cnt (err_cnt),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] exp_w[$];
  logic [31:0] exp_r[$];
  logic [31:0] slv_q[$];

  logic aw_ok, w_ok, ar_ok;
  logic bresp_err;
  logic wmon_en;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // slave model: zero-wait when *_ok is high
  logic        aw_hs, w_hs, got_aw, got_w;
  logic        aw_all, w_all;
  logic [31:0] wbuf, wcur;

  assign AWREADY = aw_ok;
  assign WREADY  = w_ok;
  assign ARREADY = ar_ok;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign aw_all  = got_aw | aw_hs;
  assign w_all   = got_w | w_hs;
  assign wcur    = w_hs ? WDATA : wbuf;

  always @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      BVALID <= 1'b0;
      BRESP  <= 2'b00;
      RVALID <= 1'b0;
      RRESP  <= 2'b00;
      RDATA  <= '0;
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      wbuf   <= '0;
      slv_q.delete();
    end else begin
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (w_hs) wbuf <= WDATA;
      if (aw_all && w_all) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        BVALID <= 1'b1;
        if (bresp_err) begin
          BRESP <= 2'b10;
        end else begin
          BRESP <= 2'b00;
          slv_q.push_back(wcur);
        end
      end else begin
        got_aw <= aw_all;
        got_w  <= w_all;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        if (slv_q.size() == 0) begin
          RRESP <= 2'b10;
          RDATA <= 32'hBAD0_BAD0;
        end else begin
          RRESP <= 2'b00;
          RDATA <= slv_q.pop_front();
        end
      end
    end
  end

  // write-channel monitor
  initial forever begin
    @(negedge ACLK);
    if (ARESET_N && wmon_en && WVALID && WREADY) begin
      if (exp_w.size() == 0) begin
        chk("w_unexpected", 32'd1, 32'd0);
      end else begin
        chk("w_data", WDATA, exp_w.pop_front());
        chk("w_addr", AWADDR, BASE);
        chk("w_strb", {28'd0, WSTRB}, 32'hF);
      end
    end
  end

  // pop-stream monitor
  initial forever begin
    @(negedge ACLK);
    if (ARESET_N && m_valid && m_ready) begin
      if (exp_r.size() == 0) begin
        chk("m_unexpected", 32'd1, 32'd0);
      end else begin
        chk("m_data", m_data, exp_r.pop_front());
      end
    end
  end

  // saturating error-count reference
  int em = 0;
  initial forever begin
    @(negedge ACLK);
    if (!ARESET_N) begin
      em = 0;
    end else begin
      chk("err_cnt", {24'd0, err_cnt}, em);
      em = em + int'(wr_err) + int'(rd_err);
      if (em > 255) em = 255;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset;
    ARESET_N = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    #2 ARESET_N = 1'b1;
    nxt;
  endtask

  // ends at posedge+1 of the cycle after the push
  task automatic push_word(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (wmon_en) exp_w.push_back(d);
    end else begin
      chk("push_timeout", 32'd0, 32'd1);
    end
    nxt;
    s_valid = 1'b0;
  endtask

  task automatic wait_mv(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("mv_timeout", 32'd0, 32'd1);
  endtask

  bit ok;
  int prev, t0, pulses;

  initial begin
    ARESET_N  = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    rd_en     = 1'b0;
    aw_ok     = 1'b1;
    w_ok      = 1'b1;
    ar_ok     = 1'b1;
    bresp_err = 1'b0;
    wmon_en   = 1'b1;
    do_reset;

    @(negedge ACLK);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("rst_wvalid", {31'd0, WVALID}, 32'd0);
    chk("rst_bready", {31'd0, BREADY}, 32'd0);
    chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("rst_rready", {31'd0, RREADY}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_errs", {30'd0, wr_err, rd_err}, 32'd0);
    nxt;

    // single write, zero-wait slave
    push_word(32'hDEAD_BEEF);
    @(negedge ACLK);
    chk("w1_awvalid", {31'd0, AWVALID}, 32'd1);
    chk("w1_wvalid", {31'd0, WVALID}, 32'd1);
    chk("w1_wdata", WDATA, 32'hDEAD_BEEF);
    chk("w1_araddr", ARADDR, BASE);
    chk("w1_prot", {26'd0, AWPROT, ARPROT}, 32'd0);
    chk("w1_s_ready_n1", {31'd0, s_ready}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("w1_bready", {31'd0, BREADY}, 32'd1);
    chk("w1_s_ready_n2", {31'd0, s_ready}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("w1_s_ready_n3", {31'd0, s_ready}, 32'd1);
    chk("w1_bready_n3", {31'd0, BREADY}, 32'd0);
    chk("w1_wr_err", {31'd0, wr_err}, 32'd0);
    nxt;

    // W accepted two cycles before AW
    aw_ok = 1'b0;
    push_word(32'h1234_5678);
    s_valid = 1'b1;
    s_data  = 32'hCAFE_0001;
    @(negedge ACLK);
    chk("sk_aw_n1", {31'd0, AWVALID}, 32'd1);
    chk("sk_w_n1", {31'd0, WVALID}, 32'd1);
    nxt;
    @(negedge ACLK);
    chk("sk_w_n2", {31'd0, WVALID}, 32'd0);
    chk("sk_aw_n2", {31'd0, AWVALID}, 32'd1);
    chk("sk_b_n2", {31'd0, BREADY}, 32'd0);
    chk("sk_sr_n2", {31'd0, s_ready}, 32'd0);
    chk("sk_wd_n2", WDATA, 32'h1234_5678);
    nxt;
    aw_ok = 1'b1;
    @(negedge ACLK);
    chk("sk_aw_n3", {31'd0, AWVALID}, 32'd1);
    chk("sk_b_n3", {31'd0, BREADY}, 32'd0);
    chk("sk_sr_n3", {31'd0, s_ready}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("sk_aw_n4", {31'd0, AWVALID}, 32'd0);
    chk("sk_b_n4", {31'd0, BREADY}, 32'd1);
    chk("sk_sr_n4", {31'd0, s_ready}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("sk_sr_n5", {31'd0, s_ready}, 32'd1);
    exp_w.push_back(32'hCAFE_0001);
    nxt;
    s_valid = 1'b0;
    repeat (4) nxt;

    // eight writes then streamed reads
    do_reset;
    for (int i = 0; i < 8; i++) push_word(i);
    repeat (4) nxt;
    for (int i = 0; i < 8; i++) exp_r.push_back(i);
    m_ready = 1'b1;
    rd_en   = 1'b1;
    t0      = cyc;
    prev    = 0;
    for (int i = 0; i < 8; i++) begin
      wait_mv(ok);
      if (!ok) break;
      if (i == 0) chk("rd_first_lat", cyc - t0, 3);
      else chk("rd_gap", cyc - prev, 4);
      prev = cyc;
      if (i == 7) rd_en = 1'b0;
      nxt;
    end
    repeat (3) nxt;
    @(negedge ACLK);
    chk("rd_idle_ar", {31'd0, ARVALID}, 32'd0);
    nxt;

    // read from empty FIFO returns SLVERR
    rd_en = 1'b1;
    nxt;
    rd_en = 1'b0;
    @(negedge ACLK);
    chk("re_arvalid", {31'd0, ARVALID}, 32'd1);
    nxt;
    @(negedge ACLK);
    chk("re_rready", {31'd0, RREADY}, 32'd1);
    nxt;
    @(negedge ACLK);
    chk("re_rd_err", {31'd0, rd_err}, 32'd1);
    chk("re_m_valid", {31'd0, m_valid}, 32'd0);
    chk("re_rready_off", {31'd0, RREADY}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("re_rd_err_off", {31'd0, rd_err}, 32'd0);
    chk("re_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("re_no_ar", {31'd0, ARVALID}, 32'd0);
    nxt;

    // pop-side backpressure
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    repeat (4) nxt;
    exp_r.push_back(32'hA5A5_0001);
    exp_r.push_back(32'hA5A5_0002);
    m_ready = 1'b0;
    rd_en   = 1'b1;
    wait_mv(ok);
    for (int i = 0; i < 10; i++) begin
      nxt;
      @(negedge ACLK);
      chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_m_data", m_data, 32'hA5A5_0001);
      chk("bp_no_ar", {31'd0, ARVALID}, 32'd0);
    end
    nxt;
    m_ready = 1'b1;
    @(negedge ACLK);
    nxt;
    @(negedge ACLK);
    chk("bp_ar_k1", {31'd0, ARVALID}, 32'd0);
    chk("bp_mv_k1", {31'd0, m_valid}, 32'd0);
    nxt;
    @(negedge ACLK);
    chk("bp_ar_k2", {31'd0, ARVALID}, 32'd1);
    rd_en = 1'b0;
    wait_mv(ok);
    nxt;
    repeat (3) nxt;

    // async reset while AW/W are pending
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    wmon_en = 1'b0;
    push_word(32'h7777_7777);
    rd_en = 1'b1;
    @(negedge ACLK);
    chk("mr_awvalid_pre", {31'd0, AWVALID}, 32'd1);
    #2 ARESET_N = 1'b0;
    #1;
    chk("mr_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("mr_wvalid", {31'd0, WVALID}, 32'd0);
    chk("mr_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("mr_bready", {31'd0, BREADY}, 32'd0);
    chk("mr_s_ready", {31'd0, s_ready}, 32'd1);
    chk("mr_wdata", WDATA, 32'd0);
    chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_err_cnt", {24'd0, err_cnt}, 32'd0);
    rd_en = 1'b0;
    aw_ok = 1'b1;
    w_ok  = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    #2 ARESET_N = 1'b1;
    nxt;

    // drive both paths into errors until saturation
    bresp_err = 1'b1;
    s_valid   = 1'b1;
    s_data    = 32'hEEEE_EEEE;
    rd_en     = 1'b1;
    pulses    = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge ACLK);
      pulses = pulses + int'(wr_err) + int'(rd_err);
      if (pulses >= 300) break;
      nxt;
    end
    s_valid = 1'b0;
    rd_en   = 1'b0;
    repeat (6) nxt;
    @(negedge ACLK);
    chk("sat_pulses", pulses >= 300, 32'd1);
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    nxt;
    bresp_err = 1'b0;
    wmon_en   = 1'b1;

    chk("exp_w_left", exp_w.size(), 32'd0);
    chk("exp_r_left", exp_r.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
